// File: rtl/gol_pkg.sv
// Shared VGA timing, colour and grid constants for the Game of Life display path.
package gol_pkg;

   localparam int VGA_CLK_DIV  = 4;
   localparam int VGA_H_VIS    = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_VIS    = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam logic SYNC_ACTIVE = 1'b0;

   localparam int GRID_N       = 16;
   localparam int GRID_CELL_PX = 24;
   localparam int GRID_X_OFF   = 128;
   localparam int GRID_Y_OFF   = 48;

   typedef logic [9:0]  cnt_t;
   typedef logic [4:0]  sub_t;
   typedef logic [11:0] rgb_t;

   localparam rgb_t COL_ALIVE = 12'h0F0;
   localparam rgb_t COL_DEAD  = 12'h111;
   localparam rgb_t COL_GRID  = 12'h444;
   localparam rgb_t COL_BLANK = 12'h000;

endpackage

// File: rtl/gol_vga_renderer_if.sv
// VGA output bundle: syncs, 12-bit colour and the board-latch strobe.
interface gol_vga_renderer_if;
   logic       hsync;
   logic       vsync;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       frame_start;

   modport master (output hsync, vsync, vga_r, vga_g, vga_b, frame_start);
   modport slave  (input  hsync, vsync, vga_r, vga_g, vga_b, frame_start);
endinterface

// File: rtl/gol_vga_timing.sv
// Pixel-rate divider and raster counters; produces raw syncs and the visible flag
// one stage ahead of the renderer's output registers.
module gol_vga_timing
   import gol_pkg::*;
#(
   parameter int CLK_DIV = VGA_CLK_DIV,
   parameter int H_VIS   = VGA_H_VIS,
   parameter int H_FP    = VGA_H_FP,
   parameter int H_SYNC  = VGA_H_SYNC,
   parameter int H_BP    = VGA_H_BP,
   parameter int V_VIS   = VGA_V_VIS,
   parameter int V_FP    = VGA_V_FP,
   parameter int V_SYNC  = VGA_V_SYNC,
   parameter int V_BP    = VGA_V_BP
) (
   input  logic clk,
   input  logic reset,
   output logic tick,
   output cnt_t h_cnt,
   output cnt_t v_cnt,
   output logic line_end,
   output logic hsync_raw,
   output logic vsync_raw,
   output logic visible
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam cnt_t H_LAST   = cnt_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_LAST   = cnt_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t HS_FIRST = cnt_t'(H_VIS + H_FP);
   localparam cnt_t HS_LAST  = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
   localparam cnt_t VS_FIRST = cnt_t'(V_VIS + V_FP);
   localparam cnt_t VS_LAST  = cnt_t'(V_VIS + V_FP + V_SYNC - 1);
   localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
   localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);

   logic [DIV_W-1:0] div_reg;
   cnt_t             h_cnt_reg;
   cnt_t             v_cnt_reg;

   assign tick      = (div_reg == DIV_LAST);
   assign line_end  = (h_cnt_reg == H_LAST);
   assign h_cnt     = h_cnt_reg;
   assign v_cnt     = v_cnt_reg;
   assign hsync_raw = (h_cnt_reg >= HS_FIRST && h_cnt_reg <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vsync_raw = (v_cnt_reg >= VS_FIRST && v_cnt_reg <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign visible   = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);

   // Reset has priority, so a tick that coincides with reset never advances anything.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_reg   <= '0;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         div_reg <= tick ? '0 : div_reg + 1'b1;
         if (tick) begin
            if (line_end) begin
               h_cnt_reg <= '0;
               v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
            end else begin
               h_cnt_reg <= h_cnt_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gol_vga_renderer.sv
// Renders the latched 16x16 Game of Life board as a VGA raster; the board is
// re-latched once per frame in vertical blank so updates never tear.
module gol_vga_renderer
   import gol_pkg::*;
#(
   parameter int CLK_DIV = VGA_CLK_DIV,
   parameter int CELL_PX = GRID_CELL_PX,
   parameter int X_OFF   = GRID_X_OFF,
   parameter int Y_OFF   = GRID_Y_OFF,
   parameter int H_VIS   = VGA_H_VIS,
   parameter int H_FP    = VGA_H_FP,
   parameter int H_SYNC  = VGA_H_SYNC,
   parameter int H_BP    = VGA_H_BP,
   parameter int V_VIS   = VGA_V_VIS,
   parameter int V_FP    = VGA_V_FP,
   parameter int V_SYNC  = VGA_V_SYNC,
   parameter int V_BP    = VGA_V_BP
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [GRID_N*GRID_N-1:0]   board,
   gol_vga_renderer_if.master         vga
);

   localparam cnt_t X_FIRST   = cnt_t'(X_OFF);
   localparam cnt_t X_END     = cnt_t'(X_OFF + GRID_N * CELL_PX);
   localparam cnt_t Y_FIRST   = cnt_t'(Y_OFF);
   localparam cnt_t Y_END     = cnt_t'(Y_OFF + GRID_N * CELL_PX);
   localparam cnt_t V_LATCH   = cnt_t'(V_VIS);
   localparam sub_t CELL_LAST = sub_t'(CELL_PX - 1);

   logic tick, line_end, hsync_raw, vsync_raw, visible;
   cnt_t h_cnt, v_cnt;

   gol_vga_timing #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .line_end  (line_end),
      .hsync_raw (hsync_raw),
      .vsync_raw (vsync_raw),
      .visible   (visible)
   );

   logic [GRID_N*GRID_N-1:0] frame_board_reg;
   sub_t       col_sub_reg, row_sub_reg, col_sub_eff, row_sub_eff;
   logic [3:0] col_reg, row_reg, col_eff, row_eff;
   logic       hsync_reg, vsync_reg, frame_start_reg, in_grid, latch_due;
   rgb_t       rgb_reg, rgb_next;

   // Counters hold the position of the current pixel; the grid origin forces them to zero.
   always_comb begin
      col_sub_eff = col_sub_reg;
      col_eff     = col_reg;
      row_sub_eff = row_sub_reg;
      row_eff     = row_reg;
      if (h_cnt == X_FIRST) begin
         col_sub_eff = '0;
         col_eff     = '0;
      end
      if (v_cnt == Y_FIRST) begin
         row_sub_eff = '0;
         row_eff     = '0;
      end
   end

   assign in_grid   = (h_cnt >= X_FIRST) && (h_cnt < X_END) && (v_cnt >= Y_FIRST) && (v_cnt < Y_END);
   assign latch_due = (h_cnt == '0) && (v_cnt == V_LATCH);

   always_comb begin
      rgb_next = COL_BLANK;
      if (visible && in_grid) begin
         if (col_sub_eff == '0 || row_sub_eff == '0)
            rgb_next = COL_GRID;
         else if (frame_board_reg[{row_eff, col_eff}])
            rgb_next = COL_ALIVE;
         else
            rgb_next = COL_DEAD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_reg       <= ~SYNC_ACTIVE;
         vsync_reg       <= ~SYNC_ACTIVE;
         rgb_reg         <= COL_BLANK;
         frame_start_reg <= 1'b0;
         frame_board_reg <= '0;
         col_sub_reg     <= '0;
         col_reg         <= '0;
         row_sub_reg     <= '0;
         row_reg         <= '0;
      end else begin
         frame_start_reg <= 1'b0;
         if (tick) begin
            hsync_reg <= hsync_raw;
            vsync_reg <= vsync_raw;
            rgb_reg   <= rgb_next;
            if (col_sub_eff == CELL_LAST) begin
               col_sub_reg <= '0;
               col_reg     <= col_eff + 1'b1;
            end else begin
               col_sub_reg <= col_sub_eff + 1'b1;
               col_reg     <= col_eff;
            end
            if (line_end) begin
               if (row_sub_eff == CELL_LAST) begin
                  row_sub_reg <= '0;
                  row_reg     <= row_eff + 1'b1;
               end else begin
                  row_sub_reg <= row_sub_eff + 1'b1;
                  row_reg     <= row_eff;
               end
            end
            if (latch_due) begin
               frame_board_reg <= board;
               frame_start_reg <= 1'b1;
            end
         end
      end
   end

   assign vga.hsync       = hsync_reg;
   assign vga.vsync       = vsync_reg;
   assign vga.vga_r       = rgb_reg[11:8];
   assign vga.vga_g       = rgb_reg[7:4];
   assign vga.vga_b       = rgb_reg[3:0];
   assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_gol_vga_renderer.sv
// Bench: a default-timing instance for 640x480 line timing, plus a shrunken-raster
// instance checked every clock against a pixel-index reference model over several frames.
module tb_gol_vga_renderer;

   localparam int S_DIV  = 2;
   localparam int S_CELL = 3;
   localparam int S_XO   = 4;
   localparam int S_YO   = 2;
   localparam int S_HV = 56, S_HF = 2, S_HS = 4, S_HB = 2;
   localparam int S_VV = 52, S_VF = 1, S_VS = 2, S_VB = 2;
   localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
   localparam int S_FRAME_CLK = S_HT * S_VT * S_DIV;

   logic         clk = 1'b0;
   logic         reset_d = 1'b1;
   logic         reset_s = 1'b1;
   logic [255:0] board_d = '0;
   logic [255:0] board_s = '0;
   logic [255:0] model_frame = '0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_s = 0;

   always #5 clk = ~clk;

   gol_vga_renderer_if vga_d ();
   gol_vga_renderer_if vga_s ();

   gol_vga_renderer dut_d (
      .clk   (clk),
      .reset (reset_d),
      .board (board_d),
      .vga   (vga_d)
   );

   gol_vga_renderer #(
      .CLK_DIV(S_DIV), .CELL_PX(S_CELL), .X_OFF(S_XO), .Y_OFF(S_YO),
      .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
   ) dut_s (
      .clk   (clk),
      .reset (reset_s),
      .board (board_s),
      .vga   (vga_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [255:0] rand_board();
      logic [255:0] b;
      for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   // Colour of raster pixel (h,v) straight from the grid geometry.
   function automatic logic [11:0] model_rgb(input int h, input int v, input logic [255:0] fb);
      int cx, cy;
      if (h >= S_HV || v >= S_VV) return 12'h000;
      if (h < S_XO || h >= S_XO + 16 * S_CELL || v < S_YO || v >= S_YO + 16 * S_CELL) return 12'h000;
      cx = h - S_XO;
      cy = v - S_YO;
      if (cx % S_CELL == 0 || cy % S_CELL == 0) return 12'h444;
      return fb[(cy / S_CELL) * 16 + cx / S_CELL] ? 12'h0F0 : 12'h111;
   endfunction

   task automatic spot(input int h, input int v, input int sh, input int sv, input string tag,
                       input logic [11:0] got, input logic [11:0] exp);
      if (h == sh && v == sv) check_eq(tag, got, exp);
   endtask

   // One clock of the small instance: n_s clocks since reset release means the
   // outputs show pixel n_s/S_DIV-1, refreshed on clocks that are multiples of S_DIV.
   task automatic step_s();
      logic        rst_edge, hs, vs, fs;
      logic [11:0] rgb, got_rgb;
      int          k, h, v;
      rst_edge = reset_s;
      @(posedge clk);
      #1;
      hs = 1'b1; vs = 1'b1; fs = 1'b0; rgb = 12'h000; h = -1; v = -1;
      if (rst_edge) begin
         n_s = 0;
         model_frame = '0;
      end else begin
         n_s++;
         if (n_s >= S_DIV) begin
            k = n_s / S_DIV - 1;
            h = k % S_HT;
            v = (k / S_HT) % S_VT;
            if (n_s % S_DIV == 0 && h == 0 && v == S_VV) begin
               model_frame = board_s;
               fs = 1'b1;
            end
            hs = !(h >= S_HV + S_HF && h < S_HV + S_HF + S_HS);
            vs = !(v >= S_VV + S_VF && v < S_VV + S_VF + S_VS);
            rgb = model_rgb(h, v, model_frame);
         end
      end
      got_rgb = {vga_s.vga_r, vga_s.vga_g, vga_s.vga_b};
      check_eq("sync", {vga_s.hsync, vga_s.vsync}, {hs, vs});
      check_eq("rgb", got_rgb, rgb);
      check_eq("frame_start", vga_s.frame_start, fs);
      if (model_frame == 256'd1) begin
         spot(h, v, 5, 3, "cell0_alive", got_rgb, 12'h0F0);
         spot(h, v, 4, 2, "grid_origin", got_rgb, 12'h444);
         spot(h, v, 7, 3, "col1_line", got_rgb, 12'h444);
         spot(h, v, 8, 3, "cell1_dead", got_rgb, 12'h111);
         spot(h, v, 2, 3, "left_border", got_rgb, 12'h000);
         spot(h, v, 53, 3, "right_border", got_rgb, 12'h000);
      end
      if (model_frame == (256'd1 << 255)) begin
         spot(h, v, 50, 48, "cell255_alive", got_rgb, 12'h0F0);
         spot(h, v, 47, 48, "cell254_dead", got_rgb, 12'h111);
      end
      if (model_frame == {256{1'b1}}) spot(h, v, 5, 3, "all_alive", got_rgb, 12'h0F0);
      if (model_frame == '0 && h >= 0) check_eq("no_alive_pre_latch", got_rgb == 12'h0F0, 1'b0);
   endtask

   task automatic run_s(input int cycles);
      repeat (cycles) step_s();
   endtask

   initial begin
      int   nd, t_fall1, t_rise, t_fall2;
      logic prev_hs;

      // Default 640x480 timing: reset values, then line timing.
      board_d = rand_board();
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("dflt_reset_out",
                  {vga_d.hsync, vga_d.vsync, vga_d.vga_r, vga_d.vga_g, vga_d.vga_b, vga_d.frame_start},
                  {1'b1, 1'b1, 12'h000, 1'b0});
      end
      reset_d = 1'b0;
      nd = 0; t_fall1 = -1; t_rise = -1; t_fall2 = -1; prev_hs = 1'b1;
      while (t_fall2 < 0 && nd < 8000) begin
         @(posedge clk);
         #1;
         nd++;
         check_eq("dflt_vsync", vga_d.vsync, 1'b1);
         check_eq("dflt_rgb_top_rows", {vga_d.vga_r, vga_d.vga_g, vga_d.vga_b}, 12'h000);
         check_eq("dflt_frame_start", vga_d.frame_start, 1'b0);
         if (prev_hs && !vga_d.hsync) begin
            if (t_fall1 < 0) t_fall1 = nd;
            else t_fall2 = nd;
         end
         if (!prev_hs && vga_d.hsync && t_fall1 >= 0 && t_rise < 0) t_rise = nd;
         prev_hs = vga_d.hsync;
      end
      check_eq("hsync_first_fall", t_fall1, 2628);
      check_eq("hsync_low_width", t_rise - t_fall1, 384);
      check_eq("hsync_period", t_fall2 - t_fall1, 3200);
      $display("phase default_timing: clocks=%0d fall=%0d rise=%0d fall2=%0d", nd, t_fall1, t_rise, t_fall2);

      // Shrunken raster, every clock against the model.
      run_s(3);
      reset_s = 1'b0;
      board_s = 256'd1;
      run_s(S_FRAME_CLK);
      $display("phase frame0_all_dead: checks=%0d", n_checks);
      board_s = 256'd1 << 255;
      run_s(S_FRAME_CLK);
      $display("phase frame1_cell0: checks=%0d", n_checks);
      board_s = '0;
      run_s(S_FRAME_CLK);
      $display("phase frame2_cell255: checks=%0d", n_checks);
      run_s(20 * S_HT * S_DIV);
      board_s = {256{1'b1}};
      run_s(S_FRAME_CLK - 20 * S_HT * S_DIV);
      $display("phase frame3_tearing: checks=%0d", n_checks);
      board_s = rand_board();
      run_s(30 * S_HT * S_DIV);
      while ((n_s + 1) % S_DIV != 0) step_s();
      reset_s = 1'b1;
      step_s();
      reset_s = 1'b0;
      $display("phase frame4_all_alive_then_reset: checks=%0d", n_checks);
      board_s = rand_board();
      run_s(S_FRAME_CLK);
      board_s = rand_board();
      run_s(S_FRAME_CLK / 2);
      $display("phase post_reset_random: checks=%0d", n_checks);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gol_vga_renderer.md
Name: gol_vga_renderer

Overview:
- Reads the 256-bit Game of Life board (16x16 cells) produced by the game machine.
- Renders it as a 640x480 @ 60 Hz VGA frame with 12-bit colour.
- Sits between the game top and the board VGA connector and consumes the machine's `board` output.
- Latches the board once per frame during vertical blank, so the display never tears while the algorithm updates mid-frame.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz clk -> 25 MHz pixel tick)
- CELL_PX, 24, cell edge in pixels (grid = 384x384)
- X_OFF, 128, first grid pixel column
- Y_OFF, 48, first grid pixel row
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800)
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- board  in  256  cell states; cell (row r, col c) = board[r*16+c], 1 = alive
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- frame_start  out  1  one-clk pulse when board is latched

Behaviour:
- Interface:
  - One clock, clk.
  - reset is synchronous and active-high, sampled only on posedge clk.
- Reset values:
  - Divider, h_cnt and v_cnt = 0.
  - hsync = vsync = 1; rgb = 0; frame_start = 0; frame_board = 0.
- Pixel tick:
  - Asserted for one clk when the divider = CLK_DIV-1; the divider then wraps to 0.
  - All counters and registered outputs advance only on the tick.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - On each h wrap, v_cnt increments over 0..524 and wraps to 0.
- Sync timing:
  - hsync low for h_cnt in [656,751].
  - vsync low for v_cnt in [490,491].
- Pipeline and latency:
  - All outputs are registered on the tick from the current counter values, giving 1 pixel tick of latency.
  - hsync, vsync and rgb stay mutually aligned.
- Cell addressing uses no divider:
  - A sub-pixel counter runs 0..CELL_PX-1 with a column counter 0..15, both reset at h_cnt = X_OFF.
  - A row sub-counter and row counter are reset at v_cnt = Y_OFF and advance per line.
  - Lookup uses frame_board[row*16+col].
- Colour, evaluated in this priority order:
  1. Blanking (h_cnt >= 640 or v_cnt >= 480): 12'h000.
  2. Outside the grid: 12'h000.
  3. Grid line (column sub-pixel = 0 or row sub-pixel = 0): 12'h444.
  4. Alive cell: 12'h0F0.
  5. Dead cell: 12'h111.
- Board latch:
  - Happens on the tick where h_cnt = 0 and v_cnt = 480.
  - frame_board <= board and frame_start pulses high for exactly one clk.
  - Board changes at any other time are invisible until the next latch.
- Reset mid-frame:
  - The next clk holds the reset values.
  - Scanning restarts at (0,0).
  - The frame shown before the first latch renders all cells dead.
- Reset while the tick is due: reset wins, and the tick is suppressed.

Decomposition:
- Package gol_pkg holds:
  - VGA timing constants and sync polarity.
  - Colour constants COL_ALIVE, COL_DEAD, COL_GRID, COL_BLANK.
  - Grid dimension GRID_N = 16.
- Sub-module gol_vga_timing holds the divider, h_cnt/v_cnt, raw syncs and the visible flag.
- The renderer holds cell counters, the frame latch and colour muxing.

Test Plan:
- Reset then run: hsync falling-edge to falling-edge = 3200 clk; hsync low width = 384 clk; outputs = reset values during reset.
- vsync period = 1,680,000 clk; vsync low width = 6400 clk; frame_start high 1 clk, 3200*480 clk after the vsync period start (v=0).
- board = 1<<0 latched: pixel (140,60) -> 12'h0F0; (128,48) -> 12'h444; (160,60) -> 12'h111; (100,60) -> 12'h000.
- board = 1<<255 latched: pixel (500,420) -> 12'h0F0; pixel (480,420) -> 12'h111.
- Tearing: board = 0 latched, then at v_cnt = 200 set board = all ones -> rest of frame rgb = 12'h111/444 only; after the next frame_start, cell interiors = 12'h0F0.
- Reset asserted at v_cnt = 300 for 1 clk: the next clk has hsync = vsync = 1 and rgb = 0; scanning restarts; all grid cells render 12'h111 until the first frame_start.
